// File: rtl/irq_controller_n.sv
// Interrupt controller: synchronised sources, pending latch, fixed priority (lowest index wins)
// and a claim/complete handshake, with ENABLE/PENDING/MODE/STATUS registers on a 64-bit bus.
module irq_controller_n #(
    parameter int                 NUM_SRC     = 4,
    parameter int                 VEC_W       = 4,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [63:0]        BASE        = 64'h8000_0020,
    parameter logic [NUM_SRC-1:0] MODE_RST    = {NUM_SRC{1'b1}}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [63:0]        bus_address,
    input  logic [63:0]        bus_write_data,
    input  logic               bus_write_enable,
    input  logic               bus_read_enable,
    output logic [63:0]        bus_read_data,
    output logic [VEC_W-1:0]   interrupt_vector,
    output logic               irq_valid,
    input  logic               interrupt_done
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                                state_q;
    logic [SYNC_STAGES-1:0][NUM_SRC-1:0]   sync_q;
    logic [NUM_SRC-1:0]                    dly_q;
    logic [NUM_SRC-1:0]                    enable_q;
    logic [NUM_SRC-1:0]                    pending_q;
    logic [NUM_SRC-1:0]                    mode_q;

    logic [NUM_SRC-1:0] synced;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] win_onehot;
    logic [NUM_SRC-1:0] claim_clr;
    logic [NUM_SRC-1:0] w1c;
    logic [VEC_W-1:0]   win_idx;
    logic               claim;
    logic               in_window;
    logic [1:0]         reg_sel;
    logic               wr_enable;
    logic               wr_pending;
    logic               wr_mode;
    logic               unused_bits;

    assign synced = sync_q[SYNC_STAGES-1];
    assign rise   = synced & ~dly_q;

    assign in_window  = (bus_address >= BASE) && (bus_address < BASE + 64'h20);
    assign reg_sel    = bus_address[4:3];
    assign wr_enable  = bus_write_enable && in_window && (reg_sel == 2'd0);
    assign wr_pending = bus_write_enable && in_window && (reg_sel == 2'd1);
    assign wr_mode    = bus_write_enable && in_window && (reg_sel == 2'd2);

    assign cand       = pending_q & enable_q;
    // Isolate the lowest set bit of the candidate vector
    assign win_onehot = cand & (~cand + NUM_SRC'(1));
    assign claim      = (state_q == IDLE) && (cand != '0);
    assign claim_clr  = claim ? win_onehot : '0;
    assign w1c        = wr_pending ? bus_write_data[NUM_SRC-1:0] : '0;

    assign unused_bits = ^{bus_read_enable, bus_write_data[63:NUM_SRC]};

    always_comb begin
        win_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (cand[i]) win_idx = VEC_W'(i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            dly_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_src};
            dly_q  <= synced;
        end
    end

    // Edge sources: a new rise wins over W1C and claim clears; level sources just follow the line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q  <= '0;
            mode_q    <= MODE_RST;
            pending_q <= '0;
        end else begin
            pending_q <= (mode_q & ((pending_q & ~(claim_clr | w1c)) | rise)) |
                         (~mode_q & synced);
            if (wr_enable) enable_q <= bus_write_data[NUM_SRC-1:0];
            if (wr_mode)   mode_q   <= bus_write_data[NUM_SRC-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            interrupt_vector <= '0;
            irq_valid        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (claim) begin
                        state_q          <= ACTIVE;
                        interrupt_vector <= win_idx + VEC_W'(1);
                        irq_valid        <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (interrupt_done) begin
                        state_q          <= IDLE;
                        interrupt_vector <= '0;
                        irq_valid        <= 1'b0;
                    end
                end
                default: begin
                    state_q          <= IDLE;
                    interrupt_vector <= '0;
                    irq_valid        <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus_read_data = '0;
        if (in_window) begin
            case (reg_sel)
                2'd0: bus_read_data = 64'(enable_q);
                2'd1: bus_read_data = 64'(pending_q);
                2'd2: bus_read_data = 64'(mode_q);
                default: begin
                    bus_read_data[63]        = irq_valid;
                    bus_read_data[VEC_W-1:0] = interrupt_vector;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller_n.sv
// Bench for irq_controller_n: directed scenarios followed by a randomized run
// compared cycle by cycle against a behavioural model of the controller.
module tb_irq_controller_n;

    localparam int          N    = 4;
    localparam int          S    = 2;
    localparam logic [63:0] BASE = 64'h8000_0020;

    logic        clk = 1'b0;
    logic        reset;
    logic [N-1:0] irq_src;
    logic [63:0] bus_address;
    logic [63:0] bus_write_data;
    logic        bus_write_enable;
    logic        bus_read_enable;
    logic [63:0] bus_read_data;
    logic [3:0]  interrupt_vector;
    logic        irq_valid;
    logic        interrupt_done;

    int n_assert = 0;
    int n_fail   = 0;

    irq_controller_n dut (
        .clk              (clk),
        .reset            (reset),
        .irq_src          (irq_src),
        .bus_address      (bus_address),
        .bus_write_data   (bus_write_data),
        .bus_write_enable (bus_write_enable),
        .bus_read_enable  (bus_read_enable),
        .bus_read_data    (bus_read_data),
        .interrupt_vector (interrupt_vector),
        .irq_valid        (irq_valid),
        .interrupt_done   (interrupt_done)
    );

    always #5 clk = ~clk;

    // behavioural model state
    logic [N-1:0] m_en, m_pend, m_mode;
    logic         m_active;
    logic [3:0]   m_vec;
    logic [N-1:0] hist[$];

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(logic [63:0] a, logic [63:0] d);
        bus_address      = a;
        bus_write_data   = d;
        bus_write_enable = 1'b1;
        tick();
        bus_write_enable = 1'b0;
    endtask

    task automatic read_check(string tag, logic [63:0] a, logic [63:0] exp);
        bus_address = a;
        #1;
        check(tag, bus_read_data, exp);
    endtask

    task automatic wait_valid(string tag, int budget);
        int k = 0;
        while (!irq_valid && k < budget) begin
            tick();
            k++;
        end
        check(tag, 64'(irq_valid), 64'd1);
    endtask

    task automatic pulse_done();
        interrupt_done = 1'b1;
        tick();
        interrupt_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        irq_src = '0;
        interrupt_done = 1'b0;
        bus_write_enable = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    function automatic logic [63:0] exp_read(logic [63:0] a);
        logic [63:0] off;
        logic [63:0] r;
        r = '0;
        if (a >= BASE && a < BASE + 64'h20) begin
            off = a - BASE;
            case (off[4:3])
                2'd0: r = 64'(m_en);
                2'd1: r = 64'(m_pend);
                2'd2: r = 64'(m_mode);
                default: r = {m_active, 59'd0, m_vec};
            endcase
        end
        return r;
    endfunction

    // Advance the model by one clock using the inputs about to be sampled.
    // hist[k] holds irq_src as sampled k+1 edges ago.
    task automatic model_step();
        logic [N-1:0] synced, prev, cand, np;
        logic [63:0]  off;
        bit           claim, in_win;
        int           win;
        synced = hist[S-1];
        prev   = hist[S];
        cand   = m_pend & m_en;
        claim  = 0;
        win    = 0;
        if (!m_active && cand != 0) begin
            claim = 1;
            for (int i = N - 1; i >= 0; i--) if (cand[i]) win = i;
        end
        in_win = (bus_address >= BASE) && (bus_address < BASE + 64'h20);
        off    = bus_address - BASE;
        for (int i = 0; i < N; i++) begin
            if (m_mode[i]) begin
                np[i] = m_pend[i];
                if (bus_write_enable && in_win && off[4:3] == 2'd1 && bus_write_data[i]) np[i] = 1'b0;
                if (claim && win == i) np[i] = 1'b0;
                if (synced[i] && !prev[i]) np[i] = 1'b1;
            end else begin
                np[i] = synced[i];
            end
        end
        if (bus_write_enable && in_win && off[4:3] == 2'd0) m_en   = bus_write_data[N-1:0];
        if (bus_write_enable && in_win && off[4:3] == 2'd2) m_mode = bus_write_data[N-1:0];
        m_pend = np;
        if (!m_active) begin
            if (claim) begin
                m_active = 1'b1;
                m_vec    = 4'(win + 1);
            end
        end else if (interrupt_done) begin
            m_active = 1'b0;
            m_vec    = '0;
        end
        hist.push_front(irq_src);
        void'(hist.pop_back());
    endtask

    initial begin
        logic [N-1:0] flip;
        int           sel;
        bus_address     = '0;
        bus_write_data  = '0;
        bus_read_enable = 1'b1;
        do_reset();

        // reset values
        check("rst vector", 64'(interrupt_vector), 64'd0);
        check("rst valid", 64'(irq_valid), 64'd0);
        read_check("rst enable", BASE, 64'd0);
        read_check("rst pending", BASE + 8, 64'd0);
        read_check("rst mode", BASE + 16, 64'hF);

        // single edge source, claim at SYNC_STAGES+2
        bus_write(BASE, 64'h1);
        irq_src = 4'b0001; tick();
        irq_src = 4'b0000; tick();
        check("t1 valid e2", 64'(irq_valid), 64'd0);
        tick();
        check("t1 valid e3", 64'(irq_valid), 64'd0);
        read_check("t1 pend e3", BASE + 8, 64'd1);
        tick();
        check("t1 vector e4", 64'(interrupt_vector), 64'd1);
        check("t1 valid e4", 64'(irq_valid), 64'd1);
        read_check("t1 pend claimed", BASE + 8, 64'd0);
        pulse_done();
        check("t1 vector done", 64'(interrupt_vector), 64'd0);
        check("t1 valid done", 64'(irq_valid), 64'd0);

        // priority, one idle cycle between claims
        bus_write(BASE, 64'hF);
        irq_src = 4'b1010; tick();
        irq_src = 4'b0000; tick(); tick(); tick();
        check("t2 first vector", 64'(interrupt_vector), 64'd2);
        read_check("t2 pend", BASE + 8, 64'd8);
        pulse_done();
        check("t2 idle gap", 64'(irq_valid), 64'd0);
        tick();
        check("t2 second vector", 64'(interrupt_vector), 64'd4);
        pulse_done();
        check("t2 idle", 64'(irq_valid), 64'd0);

        // level source re-fires while held
        bus_write(BASE + 16, 64'hB);
        irq_src = 4'b0100;
        wait_valid("t3 wait", 10);
        check("t3 vector", 64'(interrupt_vector), 64'd3);
        pulse_done();
        check("t3 gap", 64'(irq_valid), 64'd0);
        tick();
        check("t3 reclaim", 64'(interrupt_vector), 64'd3);
        irq_src = 4'b0000;
        tick(); tick(); tick(); tick();
        read_check("t3 pend low", BASE + 8, 64'd0);
        pulse_done();
        check("t3 idle1", 64'(irq_valid), 64'd0);
        tick();
        check("t3 idle2", 64'(irq_valid), 64'd0);
        bus_write(BASE + 16, 64'hF);

        // pending with enable off, W1C, set beats clear
        bus_write(BASE, 64'h0);
        irq_src = 4'b0001; tick();
        irq_src = 4'b0000; tick(); tick();
        read_check("t4 pend set", BASE + 8, 64'd1);
        check("t4 no claim", 64'(irq_valid), 64'd0);
        bus_write(BASE + 8, 64'h1);
        read_check("t4 w1c", BASE + 8, 64'd0);
        irq_src = 4'b0001; tick();
        irq_src = 4'b0000; tick();
        bus_write(BASE + 8, 64'h1);
        read_check("t4 set beats w1c", BASE + 8, 64'd1);
        bus_write(BASE, 64'h1);
        check("t4 not yet", 64'(irq_valid), 64'd0);
        tick();
        check("t4 claim", 64'(interrupt_vector), 64'd1);
        pulse_done();

        // reset during ACTIVE
        bus_write(BASE, 64'hF);
        irq_src = 4'b0010; tick();
        irq_src = 4'b0000;
        wait_valid("t5 wait", 10);
        check("t5 vector", 64'(interrupt_vector), 64'd2);
        reset = 1'b1;
        #1;
        check("t5 rst vector", 64'(interrupt_vector), 64'd0);
        check("t5 rst valid", 64'(irq_valid), 64'd0);
        read_check("t5 rst enable", BASE, 64'd0);
        read_check("t5 rst mode", BASE + 16, 64'hF);
        reset = 1'b0;
        pulse_done();
        check("t5 stray done", 64'(irq_valid), 64'd0);
        check("t5 stray vector", 64'(interrupt_vector), 64'd0);

        // STATUS and window decode
        bus_write(BASE, 64'hF);
        irq_src = 4'b0100; tick();
        irq_src = 4'b0000;
        wait_valid("t6 wait", 10);
        read_check("t6 status", BASE + 24, 64'h8000_0000_0000_0003);
        read_check("t6 outside hi", BASE + 64'h40, 64'd0);
        read_check("t6 outside lo", BASE - 8, 64'd0);
        bus_write(BASE + 24, '1);
        read_check("t6 status ro", BASE + 24, 64'h8000_0000_0000_0003);
        bus_write(BASE + 32, 64'h0);
        read_check("t6 alias ignored", BASE, 64'hF);
        pulse_done();

        // randomized run against the model
        do_reset();
        m_en = '0; m_pend = '0; m_mode = '1; m_active = 1'b0; m_vec = '0;
        hist.delete();
        for (int k = 0; k <= S; k++) hist.push_back('0);
        for (int n = 0; n < 600; n++) begin
            flip = N'($urandom) & N'($urandom);
            irq_src = irq_src ^ flip;
            interrupt_done = m_active ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            bus_write_enable = ($urandom_range(0, 4) == 0);
            bus_write_data = {$urandom, $urandom};
            sel = $urandom_range(0, 5);
            if (sel < 4) bus_address = BASE + 64'(sel * 8);
            else if (sel == 4) bus_address = BASE + 64'h40;
            else bus_address = BASE - 8;
            model_step();
            tick();
            check($sformatf("rnd vector c%0d", n), 64'(interrupt_vector), 64'(m_vec));
            check($sformatf("rnd valid c%0d", n), 64'(irq_valid), 64'(m_active));
            check($sformatf("rnd read c%0d a%h", n, bus_address), bus_read_data, exp_read(bus_address));
        end
        bus_write_enable = 1'b0;
        interrupt_done = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
